// File: rtl/alu_operand_sequencer_if.sv
// Bus between the control unit / ALU and the operand sequencer.
// slave = sequencer side, master = control unit + ALU side.
interface alu_operand_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  // start is a level request sampled only while the sequencer is idle. It is
  // not held off by busy. Completion is the one-cycle done pulse.
  logic              start;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              clr_ovf;
  logic [DATA_W-1:0] alu_result;
  logic [1:0]        alu_flags;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic              sigALUOp;
  logic              busy;
  logic              done;
  logic [1:0]        flags;
  logic              ovf_sticky;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [1:0]        dbg_state;

  modport slave (
    input  start, rs1, rs2, rd, ld_en, ld_addr, ld_data, clr_ovf,
           alu_result, alu_flags, dbg_addr,
    output operand1, operand2, sigALUOp, busy, done, flags, ovf_sticky,
           dbg_data, dbg_state
  );

  modport master (
    output start, rs1, rs2, rd, ld_en, ld_addr, ld_data, clr_ovf,
           alu_result, alu_flags, dbg_addr,
    input  operand1, operand2, sigALUOp, busy, done, flags, ovf_sticky,
           dbg_data, dbg_state
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Register file plus IDLE->FETCH->EXEC->WRITE sequencer that feeds the ALU
// and writes its result back. It tracks the last flags and a sticky overflow bit.
module alu_operand_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int REG_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_operand_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_busy;
  logic              w_alu_op;

  logic [DATA_W-1:0] r_regs [REG_COUNT];
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [DATA_W-1:0] r_result;
  logic [1:0]        r_cap_flags;
  logic [1:0]        r_flags;
  logic              r_sticky;
  logic              r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b1;
    w_alu_op = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_EXEC;
      S_EXEC: begin
        w_alu_op = 1'b1;
        w_next   = S_WRITE;
      end
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Loads and writeback share the array but live in different states, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_result    <= '0;
      r_cap_flags <= '0;
      r_flags     <= '0;
      r_sticky    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_WRITE);
      case (r_state)
        S_IDLE: begin
          if (bus.ld_en) r_regs[bus.ld_addr] <= bus.ld_data;
          if (bus.start) begin
            r_rs1 <= bus.rs1;
            r_rs2 <= bus.rs2;
            r_rd  <= bus.rd;
          end
        end
        S_FETCH: begin
          r_op1 <= r_regs[r_rs1];
          r_op2 <= r_regs[r_rs2];
        end
        S_EXEC: begin
          r_result    <= bus.alu_result;
          r_cap_flags <= bus.alu_flags;
        end
        S_WRITE: begin
          r_regs[r_rd] <= r_result;
          r_flags      <= r_cap_flags;
        end
        default: ;
      endcase
      // A write that overflows takes priority over a coincident clear.
      if (r_state == S_WRITE && r_cap_flags[1]) r_sticky <= 1'b1;
      else if (bus.clr_ovf)                     r_sticky <= 1'b0;
    end
  end

  assign bus.operand1   = r_op1;
  assign bus.operand2   = r_op2;
  assign bus.sigALUOp   = w_alu_op;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.flags      = r_flags;
  assign bus.ovf_sticky = r_sticky;
  assign bus.dbg_data   = r_regs[bus.dbg_addr];
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a behavioural adder ALU.
// It uses a shadow register file and a queue of expected writebacks.
module tb_alu_operand_sequencer;
  localparam int DW = 8;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  alu_operand_sequencer #(.DATA_W(DW), .ADDR_W(AW), .REG_COUNT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [1:0] add_flags(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {(a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]), s[DW]};
  endfunction

  // ALU: sum plus {signed overflow, carry}
  assign bus.alu_result = bus.operand1 + bus.operand2;
  assign bus.alu_flags  = add_flags(bus.operand1, bus.operand2);

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_ops    = 0;
  logic [DW-1:0] m_regs [4];
  logic          m_sticky = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [1:0]    expf_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest issued operation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("wb_data", 32'(bus.dbg_data), 32'(exp_q.pop_front()));
        check("flags",   32'(bus.flags),    32'(expf_q.pop_front()));
      end
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    tick();
    bus.ld_en = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic check_all_zero();
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = AW'(i);
      #1;
      check("reg_zero", 32'(bus.dbg_data), 32'd0);
    end
    check("flags_zero",  32'(bus.flags),      32'd0);
    check("sticky_zero", 32'(bus.ovf_sticky), 32'd0);
    check("idle_busy",   32'(bus.busy),       32'd0);
    check("idle_state",  32'(bus.dbg_state),  32'd0);
  endtask

  // Drives start in the current cycle and ends in the done cycle, so a
  // following call issues back-to-back.
  task automatic run_op(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input bit clr_in_write, input bit poke,
                        input bit with_ld, input logic [AW-1:0] ld_a, input logic [DW-1:0] ld_d);
    logic [DW-1:0] a, b, s;
    logic [1:0]    f;
    if (with_ld) begin
      bus.ld_en = 1'b1; bus.ld_addr = ld_a; bus.ld_data = ld_d;
      m_regs[ld_a] = ld_d;
    end
    a = m_regs[rs1]; b = m_regs[rs2]; s = a + b; f = add_flags(a, b);
    exp_q.push_back(s); expf_q.push_back(f);
    n_ops++;
    bus.start = 1'b1; bus.rs1 = rs1; bus.rs2 = rs2; bus.rd = rd;
    tick();
    bus.start = 1'b0; bus.ld_en = 1'b0; bus.dbg_addr = rd;
    check("fetch_state", 32'(bus.dbg_state), 32'd1);
    check("fetch_busy",  32'(bus.busy),      32'd1);
    check("fetch_aluop", 32'(bus.sigALUOp),  32'd0);
    check("fetch_done",  32'(bus.done),      32'd0);
    if (poke) begin
      bus.start = 1'b1; bus.ld_en = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 8'hFF;
    end
    tick();
    bus.start = 1'b0; bus.ld_en = 1'b0;
    check("exec_aluop", 32'(bus.sigALUOp), 32'd1);
    check("exec_op1",   32'(bus.operand1), 32'(a));
    check("exec_op2",   32'(bus.operand2), 32'(b));
    if (clr_in_write) bus.clr_ovf = 1'b1;
    tick();
    check("write_aluop", 32'(bus.sigALUOp), 32'd0);
    check("write_busy",  32'(bus.busy),     32'd1);
    check("write_done",  32'(bus.done),     32'd0);
    tick();
    bus.clr_ovf = 1'b0;
    m_sticky = f[1] ? 1'b1 : (clr_in_write ? 1'b0 : m_sticky);
    m_regs[rd] = s;
    check("done_pulse", 32'(bus.done),       32'd1);
    check("done_busy",  32'(bus.busy),       32'd0);
    check("sticky",     32'(bus.ovf_sticky), 32'(m_sticky));
    check("op1_hold",   32'(bus.operand1),   32'(a));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.start = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0;
    bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.clr_ovf = 0; bus.dbg_addr = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    idle_cycles(2);
    reset = 1'b1;
    check_all_zero();

    // Basic add
    load(2'd0, 8'h12); load(2'd1, 8'h34);
    run_op(2'd0, 2'd1, 2'd2, 0, 0, 0, 2'd0, 8'h00);
    idle_cycles(2);

    // Overflow, then clear alone
    load(2'd0, 8'h70); load(2'd1, 8'h20);
    run_op(2'd0, 2'd1, 2'd3, 0, 0, 0, 2'd0, 8'h00);
    tick();
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0; m_sticky = 1'b0;
    check("clr_ovf", 32'(bus.ovf_sticky), 32'd0);

    // Set wins over clear
    run_op(2'd0, 2'd1, 2'd3, 1, 0, 0, 2'd0, 8'h00);
    tick();

    // Hazard rd == rs1, back-to-back
    load(2'd0, 8'h01); load(2'd1, 8'h01);
    run_op(2'd0, 2'd1, 2'd0, 0, 0, 0, 2'd0, 8'h00);
    run_op(2'd0, 2'd1, 2'd0, 0, 0, 0, 2'd0, 8'h00);
    check("hazard_r0", 32'(bus.dbg_data), 32'h03);
    tick();

    // start and ld_en while busy are ignored
    run_op(2'd2, 2'd3, 2'd0, 0, 1, 0, 2'd0, 8'h00);
    idle_cycles(5);
    bus.dbg_addr = 2'd1; #1;
    check("ignored_ld_r1", 32'(bus.dbg_data), 32'(m_regs[1]));

    // Load and start in the same cycle: FETCH sees the loaded value
    run_op(2'd2, 2'd1, 2'd3, 0, 0, 1, 2'd2, 8'h5A);
    tick();

    // Random operations with random clears
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) load(AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)));
      run_op(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), 0, 0, 2'd0, 8'h00);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset mid-EXEC aborts the operation
    load(2'd0, 8'h70); load(2'd1, 8'h20);
    bus.start = 1'b1; bus.rs1 = 2'd0; bus.rs2 = 2'd1; bus.rd = 2'd2;
    tick(); bus.start = 1'b0;
    tick();
    check("pre_reset_exec", 32'(bus.sigALUOp), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_sticky = 1'b0;
    check_all_zero();
    idle_cycles(6);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count",  32'(n_done),       32'(n_ops));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
